// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the ALU, the decoder and the EX->MEM result stage.
//   - ALU opcode encodings
//   - ex_mem_t: payload carried from EX to MEM
//   - is_trap_op(): opcodes whose signed overflow raises a trap
package cpu_pkg;

    localparam int unsigned WORD_LEN     = 32;
    localparam int unsigned REG_ADDR_LEN = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [WORD_LEN-1:0]     res;
        logic                    zero;
        logic [REG_ADDR_LEN-1:0] rd;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic [WORD_LEN-1:0]     store_data;
    } ex_mem_t;

    // SLT reports carry-out on the overflow line, so only ADD/SUB overflow is a real trap.
    function automatic logic is_trap_op(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer (output slot + skid slot).
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready is ~skid_full (register-only path)
//   in_data              payload of type T
//   flush                drop both slots and the incoming word this cycle
//   out_valid/out_ready  downstream handshake
//   out_data             output slot payload; holds its value when out_valid=0
module skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    input  logic flush,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic r_out_valid;
    T     r_out_data;
    logic r_skid_valid;
    T     r_skid_data;

    logic w_push;
    logic w_slot_free;

    assign in_ready    = ~r_skid_valid;
    assign w_push      = in_valid & ~r_skid_valid & ~flush;
    // Output slot can take a new word when empty or being consumed this cycle.
    assign w_slot_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Data registers are left untouched so out_data holds its last value.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_slot_free) begin
            if (r_skid_valid) begin
                // Skid full implies in_ready=0, so no push can coincide here.
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->MEM pipeline register stage downstream of the ALU.
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          upstream handshake; in_ready = ~skid_full & ~exc_overflow
//   res, zero, overflow, op    ALU outputs and the opcode that produced them
//   rd, reg_write, mem_read, mem_write, store_data   instruction control/data fields
//   flush                      kill every held or arriving instruction this cycle
//   out_valid/out_ready        MEM-stage handshake
//   out_*                      registered copies of the captured fields
//   exc_overflow/exc_ack       sticky signed-overflow trap and its acknowledge
// wordLen/regAddrLen must equal cpu_pkg::WORD_LEN/REG_ADDR_LEN (ex_mem_t is fixed-width).
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int unsigned wordLen    = WORD_LEN,
    parameter int unsigned regAddrLen = REG_ADDR_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [wordLen-1:0]    res,
    input  logic                  zero,
    input  logic                  overflow,
    input  logic [3:0]            op,
    input  logic [regAddrLen-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [wordLen-1:0]    store_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [wordLen-1:0]    out_res,
    output logic                  out_zero,
    output logic [regAddrLen-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [wordLen-1:0]    out_store_data,
    output logic                  exc_overflow,
    input  logic                  exc_ack
);

    logic    r_exc_overflow;
    logic    w_buf_ready;
    logic    w_accept;
    logic    w_trap;
    ex_mem_t w_in_entry;
    ex_mem_t w_out_entry;

    assign in_ready = w_buf_ready & ~r_exc_overflow;
    assign w_accept = in_valid & in_ready & ~flush;
    assign w_trap   = w_accept & overflow & is_trap_op(op);

    // A trapping instruction still flows down the pipe but with every side effect stripped.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.res        = res;
        w_in_entry.zero       = zero;
        w_in_entry.rd         = rd;
        w_in_entry.reg_write  = reg_write & ~w_trap;
        w_in_entry.mem_read   = mem_read  & ~w_trap;
        w_in_entry.mem_write  = mem_write & ~w_trap;
        w_in_entry.store_data = store_data;
    end

    skid_buffer #(
        .T (ex_mem_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid & ~r_exc_overflow),
        .in_ready  (w_buf_ready),
        .in_data   (w_in_entry),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_entry)
    );

    // New trap wins over a same-cycle ack; flush deliberately leaves the trap pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exc_overflow <= 1'b0;
        end else if (w_trap) begin
            r_exc_overflow <= 1'b1;
        end else if (exc_ack) begin
            r_exc_overflow <= 1'b0;
        end
    end

    assign exc_overflow   = r_exc_overflow;
    assign out_res        = w_out_entry.res;
    assign out_zero       = w_out_entry.zero;
    assign out_rd         = w_out_entry.rd;
    assign out_reg_write  = w_out_entry.reg_write;
    assign out_mem_read   = w_out_entry.mem_read;
    assign out_mem_write  = w_out_entry.mem_write;
    assign out_store_data = w_out_entry.store_data;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based transaction model of the stage.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] res = '0;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic [3:0]  op = 4'b0000;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] store_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [31:0] out_store_data;
    logic        exc_overflow;
    logic        exc_ack = 1'b0;

    alu_result_stage #(
        .wordLen    (32),
        .regAddrLen (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .res            (res),
        .zero           (zero),
        .overflow       (overflow),
        .op             (op),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .store_data     (store_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_res        (out_res),
        .out_zero       (out_zero),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data),
        .exc_overflow   (exc_overflow),
        .exc_ack        (exc_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
        logic [2:0]  flags; // {reg_write, mem_read, mem_write}
        logic [31:0] sd;
    } ent_t;

    ent_t q[$];
    ent_t last_shown = '0;
    bit   m_exc = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        e = (q.size() > 0) ? q[0] : last_shown;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !m_exc));
        chk("exc_overflow", 64'(exc_overflow), 64'(m_exc));
        chk("out_res", 64'(out_res), 64'(e.res));
        chk("out_zero", 64'(out_zero), 64'(e.zero));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_flags", 64'({out_reg_write, out_mem_read, out_mem_write}), 64'(e.flags));
        chk("out_store_data", 64'(out_store_data), 64'(e.sd));
    endtask

    // Advance the model by one clock using the inputs currently driven, then check.
    task automatic do_cycle();
        bit   rdy;
        bit   acc;
        bit   trap;
        ent_t e;
        rdy  = (q.size() < 2) && !m_exc;
        acc  = in_valid && rdy && !flush;
        trap = acc && overflow && (op == 4'b0010 || op == 4'b0110);
        e.res   = res;
        e.zero  = zero;
        e.rd    = rd;
        e.flags = trap ? 3'b000 : {reg_write, mem_read, mem_write};
        e.sd    = store_data;
        if (flush) begin
            if (q.size() > 0) last_shown = q[0];
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) begin
                last_shown = q[0];
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        if (trap) m_exc = 1'b1;
        else if (exc_ack) m_exc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input bit v, input logic [3:0] o, input bit ovf, input bit rw,
                          input bit rdy, input bit fl, input bit ack);
        in_valid   = v;
        op         = o;
        overflow   = ovf;
        reg_write  = rw;
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        res        = $urandom;
        zero       = (res == 0);
        rd         = 5'($urandom);
        store_data = $urandom;
        out_ready  = rdy;
        flush      = fl;
        exc_ack    = ack;
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // 1: streaming ADDs with out_ready high
        for (int i = 0; i < 8; i++) begin
            set_in(1, 4'b0010, 0, 1, 1, 0, 0);
            do_cycle();
        end
        set_in(0, 4'b0000, 0, 0, 1, 0, 0);
        repeat (2) do_cycle();

        // 2: backpressure for 3 cycles mid-stream
        for (int i = 0; i < 10; i++) begin
            set_in(1, 4'b0110, 0, 1, !(i >= 3 && i < 6), 0, 0);
            do_cycle();
        end
        set_in(0, 4'b0000, 0, 0, 1, 0, 0);
        repeat (3) do_cycle();

        // 3: ADD overflow trap, input stays blocked until ack
        set_in(1, 4'b0010, 1, 1, 1, 0, 0);
        res = 32'h8000_0000;
        do_cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'b0000, 0, 1, 1, 0, 0);
            do_cycle();
        end
        set_in(0, 4'b0000, 0, 0, 1, 0, 1);
        do_cycle();

        // 4: SLT overflow never traps
        set_in(1, 4'b0111, 1, 1, 1, 0, 0);
        do_cycle();
        set_in(0, 4'b0000, 0, 0, 1, 0, 0);
        repeat (2) do_cycle();

        // 5: flush with both slots full and in_valid high
        for (int i = 0; i < 2; i++) begin
            set_in(1, 4'b0001, 0, 1, 0, 0, 0);
            do_cycle();
        end
        set_in(1, 4'b0001, 0, 1, 1, 1, 0);
        do_cycle();
        set_in(0, 4'b0000, 0, 0, 1, 0, 0);
        repeat (2) do_cycle();

        // 6: asynchronous reset during a stall with a trap pending
        set_in(1, 4'b0010, 1, 1, 0, 0, 0);
        do_cycle();
        set_in(0, 4'b0000, 0, 0, 0, 0, 0);
        do_cycle();
        #2 reset = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_exc", 64'(exc_overflow), 64'd0);
        q.delete();
        m_exc = 1'b0;
        last_shown = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_outputs();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 4'b0010, 0, 1, 1, 0, 0);
            do_cycle();
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 9) < 7, ops[$urandom_range(0, 5)],
                   $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 19) < 3);
            do_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
